// File: rtl/oam_dma_ctrl.sv
// Sprite DMA sequencer: a CPU write to DMA_REG_ADDR takes the bus and copies one
// 256-byte CPU page into OAM through repeated writes to OAMDATA.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter bit          ALIGN_EN      = 1'b1
) (
  input  logic        cpu_clk,
  input  logic        reset,
  input  logic [15:0] bus_addr,
  input  logic [7:0]  bus_din,
  input  logic        bus_wr,
  input  logic        odd_or_even,
  input  logic [7:0]  mem_rdata,
  output logic        dma_hijack,
  output logic [15:0] dma_bus_addr,
  output logic        dma_bus_wr,
  output logic [7:0]  dma_bus_dout,
  output logic        dma_busy,
  output logic        dma_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_e;

  typedef struct packed {
    logic [15:0] addr;
    logic        wr;    // 1 = read, 0 = write
    logic [7:0]  dout;
  } dma_bus_t;

  state_e   state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q,  idx_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;
  dma_bus_t   bus;

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    data_d  = data_q;
    done_d  = 1'b0;
    bus     = '{addr: 16'h0000, wr: 1'b1, dout: 8'h00};
    unique case (state_q)
      S_IDLE: begin
        if (bus_addr == DMA_REG_ADDR && !bus_wr) begin
          page_d  = bus_din;
          idx_d   = 8'h00;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        // dummy read while the CPU stalls; an odd halt needs one extra cycle
        bus.addr = {page_q, 8'h00};
        state_d  = (ALIGN_EN && odd_or_even) ? S_ALIGN : S_READ;
      end
      S_ALIGN: begin
        bus.addr = {page_q, 8'h00};
        state_d  = S_READ;
      end
      S_READ: begin
        bus.addr = {page_q, idx_q};
        data_d   = mem_rdata;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        bus.addr = OAM_DATA_ADDR;
        bus.wr   = 1'b0;
        bus.dout = data_q;
        idx_d    = idx_q + 8'd1;  // wraps within the page, never carries into page
        if (idx_q == 8'hFF) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dma_hijack   = (state_q != S_IDLE);
  assign dma_busy     = dma_hijack;
  assign dma_bus_addr = bus.addr;
  assign dma_bus_wr   = bus.wr;
  assign dma_bus_dout = bus.dout;
  assign dma_done     = done_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: vector table for non-trigger bus traffic, plus
// scoreboarded full transfers covering parity, retrigger, chaining, page FF and reset.
module tb_oam_dma_ctrl;

  logic        cpu_clk = 1'b0;
  logic        reset;
  logic [15:0] bus_addr;
  logic [7:0]  bus_din;
  logic        bus_wr;
  logic        odd_or_even;
  logic [7:0]  mem_rdata;
  logic        dma_hijack;
  logic [15:0] dma_bus_addr;
  logic        dma_bus_wr;
  logic [7:0]  dma_bus_dout;
  logic        dma_busy;
  logic        dma_done;

  oam_dma_ctrl dut (
    .cpu_clk      (cpu_clk),
    .reset        (reset),
    .bus_addr     (bus_addr),
    .bus_din      (bus_din),
    .bus_wr       (bus_wr),
    .odd_or_even  (odd_or_even),
    .mem_rdata    (mem_rdata),
    .dma_hijack   (dma_hijack),
    .dma_bus_addr (dma_bus_addr),
    .dma_bus_wr   (dma_bus_wr),
    .dma_bus_dout (dma_bus_dout),
    .dma_busy     (dma_busy),
    .dma_done     (dma_done)
  );

  always #5 cpu_clk = ~cpu_clk;

  // page 02 holds i^5A; other pages are distinguishable by the high byte
  function automatic logic [7:0] memf(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'h02);
  endfunction

  assign mem_rdata = memf(dma_bus_addr);

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [7:0]  din;
    logic        exp_hij;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] sb[$];
  logic [7:0] cur_page;
  int cyc = 0, hij_cnt = 0, wr_cnt = 0, done_cnt = 0, bad_cnt = 0;
  int hstart = 0, first_wr = 0, last_wr = 0, done_cyc = 0, xfer_wr = 0;
  logic hij_prev = 1'b0;
  int b_hij, b_wr, b_done, b_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic bus_idle();
    bus_addr = 16'h0000;
    bus_wr   = 1'b1;
    bus_din  = 8'h00;
  endtask

  task automatic drive_trig(input logic [7:0] pg, input logic odd);
    bus_addr    = 16'h4014;
    bus_wr      = 1'b0;
    bus_din     = pg;
    odd_or_even = odd;
    for (int i = 0; i < 256; i++) sb.push_back(memf({pg, 8'(i)}));
    cur_page = pg;
    b_hij  = hij_cnt;
    b_wr   = wr_cnt;
    b_done = done_cnt;
    b_bad  = bad_cnt;
  endtask

  // Entered at posedge+1 with the trigger already latched; returns at posedge+1.
  task automatic wait_done(input logic odd, input bit retrig, input bit chain,
                           input logic [7:0] npg, input logic nodd);
    bit seen = 0;
    for (int n = 0; n < 700; n++) begin
      if (retrig && n == 60) begin
        bus_addr = 16'h4014; bus_wr = 1'b0; bus_din = 8'h07;
      end
      if (retrig && n == 61) bus_idle();
      @(posedge cpu_clk); #1;
      if (dma_done) begin seen = 1; break; end
    end
    if (!seen) begin
      chk("done_timeout", 32'd0, 32'd1);
      return;
    end
    @(negedge cpu_clk);
    chk("hijack_cycles",  hij_cnt - b_hij, odd ? 32'd514 : 32'd513);
    chk("oam_writes",     wr_cnt - b_wr, 32'd256);
    chk("first_write_ofs", first_wr - hstart, odd ? 32'd3 : 32'd2);
    chk("done_timing",    done_cyc, last_wr + 1);
    chk("done_pulses",    done_cnt - b_done, 32'd1);
    chk("src_page_reads", bad_cnt - b_bad, 32'd0);
    chk("sb_empty",       sb.size(), 32'd0);
    chk("hijack_off_at_done", dma_hijack, 1'b0);
    if (chain) drive_trig(npg, nodd);
    @(posedge cpu_clk); #1;
    bus_idle();
    chk("done_one_cycle", dma_done, 1'b0);
  endtask

  initial begin
    vec_t vecs[5];
    vecs[0] = '{16'h4014, 1'b1, 8'h02, 1'b0};  // CPU read of $4014
    vecs[1] = '{16'h4015, 1'b0, 8'h02, 1'b0};
    vecs[2] = '{16'h4013, 1'b0, 8'h02, 1'b0};
    vecs[3] = '{16'h0014, 1'b0, 8'h02, 1'b0};
    vecs[4] = '{16'hC014, 1'b0, 8'h02, 1'b0};

    reset = 1'b1;
    odd_or_even = 1'b0;
    cur_page = 8'h00;
    bus_idle();

    fork
      forever begin
        @(negedge cpu_clk);
        if (dma_hijack && !hij_prev) begin hstart = cyc; xfer_wr = 0; end
        if (dma_busy !== dma_hijack) chk("busy_eq_hijack", dma_busy, dma_hijack);
        if (dma_hijack) begin
          hij_cnt++;
          if (dma_bus_wr && dma_bus_addr[15:8] != cur_page) bad_cnt++;
          if (!dma_bus_wr) begin
            if (xfer_wr == 0) first_wr = cyc;
            xfer_wr++;
            wr_cnt++;
            last_wr = cyc;
            chk("oam_addr", dma_bus_addr, 16'h2004);
            if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else chk("oam_data", dma_bus_dout, sb.pop_front());
          end
        end
        if (dma_done) begin done_cnt++; done_cyc = cyc; end
        hij_prev = dma_hijack;
        cyc++;
      end
    join_none

    repeat (2) @(posedge cpu_clk);
    #1;
    chk("rst_hijack", dma_hijack, 1'b0);
    chk("rst_busy",   dma_busy, 1'b0);
    chk("rst_done",   dma_done, 1'b0);
    chk("rst_addr",   dma_bus_addr, 16'h0000);
    chk("rst_wr",     dma_bus_wr, 1'b1);
    chk("rst_dout",   dma_bus_dout, 8'h00);
    reset = 1'b0;
    @(posedge cpu_clk); #1;

    foreach (vecs[i]) begin
      bus_addr = vecs[i].addr;
      bus_wr   = vecs[i].wr;
      bus_din  = vecs[i].din;
      @(posedge cpu_clk); #1;
      bus_idle();
      @(negedge cpu_clk);
      chk("vec_hijack", dma_hijack, vecs[i].exp_hij);
      chk("vec_addr",   dma_bus_addr, 16'h0000);
      chk("vec_wr",     dma_bus_wr, 1'b1);
      chk("vec_dout",   dma_bus_dout, 8'h00);
      @(posedge cpu_clk); #1;
    end

    // even start
    drive_trig(8'h02, 1'b0);
    @(posedge cpu_clk); #1;
    bus_idle();
    wait_done(1'b0, 0, 0, 8'h00, 1'b0);

    // odd start with a retrigger attempt, chained into page FF on the done cycle
    drive_trig(8'h02, 1'b1);
    @(posedge cpu_clk); #1;
    bus_idle();
    wait_done(1'b1, 1, 1, 8'hFF, 1'b0);
    wait_done(1'b0, 0, 0, 8'h00, 1'b0);

    // reset after write #100
    drive_trig(8'h02, 1'b0);
    @(posedge cpu_clk); #1;
    bus_idle();
    for (int n = 0; n < 400 && (wr_cnt - b_wr) < 100; n++) begin
      @(posedge cpu_clk); #1;
    end
    chk("reached_write_100", wr_cnt - b_wr, 32'd100);
    reset = 1'b1;
    @(posedge cpu_clk); #1;
    reset = 1'b0;
    @(negedge cpu_clk);
    chk("rst_mid_hijack", dma_hijack, 1'b0);
    chk("rst_mid_writes", wr_cnt - b_wr, 32'd100);
    chk("rst_mid_addr",   dma_bus_addr, 16'h0000);
    chk("rst_mid_wr",     dma_bus_wr, 1'b1);
    sb.delete();
    repeat (3) @(posedge cpu_clk);
    #1;
    chk("rst_mid_no_done", done_cnt - b_done, 32'd0);

    drive_trig(8'h03, 1'b0);
    @(posedge cpu_clk); #1;
    bus_idle();
    wait_done(1'b0, 0, 0, 8'h00, 1'b0);

    repeat (2) @(posedge cpu_clk);
    #1;
    chk("final_idle", dma_hijack, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
